// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM state encoding and feedback-mode constants.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int FIBONACCI = 0;
  localparam int GALOIS    = 1;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step, Fibonacci shift-in or Galois XOR-mask form.
module lfsr_step #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
  parameter int               GALOIS = 0
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (GALOIS == lfsr_pkg::GALOIS) begin : g_galois
      assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : {WIDTH{1'b0}});
    end else begin : g_fibonacci
      assign nxt = {^(cur & TAPS), cur[WIDTH-1:1]};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with single-step, counted-burst and load control.
// Optional zero-state recovery with lockup pulse when LFSR_GEN_LOCKUP_EN is defined.
module lfsr_gen #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
  parameter logic [WIDTH-1:0] SEED   = 8'h01,
  parameter int               GALOIS = 0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] state_out,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  import lfsr_pkg::*;

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] step_raw, step_val, load_val;
  logic             do_step;

  lfsr_step #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .GALOIS (GALOIS)
  ) u_step (
    .cur (lfsr_q),
    .nxt (step_raw)
  );

`ifdef LFSR_GEN_LOCKUP_EN
  logic lockup_q, lockup_d;

  // An all-zero state would never leave zero, so both load and step paths fall back to SEED.
  assign load_val = (seed_in == '0)  ? SEED : seed_in;
  assign step_val = (step_raw == '0) ? SEED : step_raw;
  assign lockup_d = load ? (seed_in == '0) : (do_step && (step_raw == '0));
  assign lockup   = lockup_q;

  always_ff @(posedge clk) begin
    if (rst) lockup_q <= 1'b0;
    else     lockup_q <= lockup_d;
  end
`else
  assign load_val = seed_in;
  assign step_val = step_raw;
  assign lockup   = 1'b0;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    do_step = 1'b0;
    if (load) begin
      fsm_d = IDLE;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (burst_start) begin
            if (burst_len == '0) begin
              fsm_d = DONE;
            end else begin
              fsm_d = RUN;
              cnt_d = burst_len;
            end
          end else begin
            do_step = en;
          end
        end
        RUN: begin
          do_step = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) fsm_d = DONE;
        end
        DONE:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  assign lfsr_d = load ? load_val : (do_step ? step_val : lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      fsm_q  <= IDLE;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
    end
  end

  assign state_out = lfsr_q;
  assign bit_out   = lfsr_q[0];
  assign busy      = (fsm_q == RUN);
  assign done      = (fsm_q == DONE);

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: Fibonacci and Galois instances driven in lockstep.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst, load, en, burst_start;
  logic [7:0]  seed_in;
  logic [15:0] burst_len;

  logic [7:0] st_f, st_g;
  logic       bit_f, bit_g, busy_f, busy_g, done_f, done_g, lock_f, lock_g;

  always #5 clk = ~clk;

  lfsr_gen dut_f (
    .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .en(en),
    .burst_start(burst_start), .burst_len(burst_len),
    .state_out(st_f), .bit_out(bit_f), .busy(busy_f), .done(done_f), .lockup(lock_f)
  );

  lfsr_gen #(.GALOIS(1)) dut_g (
    .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .en(en),
    .burst_start(burst_start), .burst_len(burst_len),
    .state_out(st_g), .bit_out(bit_g), .busy(busy_g), .done(done_g), .lockup(lock_g)
  );

`ifdef LFSR_GEN_LOCKUP_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int M_TAPS = 'h1D;
  localparam int M_SEED = 'h01;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic on the sequence rules, burst tracked as steps remaining.
  int m_f, m_g, m_left;
  bit m_running, m_done, m_lock_f, m_lock_g;

  function automatic int ref_fib(input int s);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += ((s >> i) & 1) & ((M_TAPS >> i) & 1);
    return ((ones % 2) * 128) + (s / 2);
  endfunction

  function automatic int ref_gal(input int s);
    return (s / 2) ^ ((s % 2 == 1) ? M_TAPS : 0);
  endfunction

  task automatic model_adv();
    m_f = ref_fib(m_f);
    m_g = ref_gal(m_g);
    if (LOCK_EN && m_f == 0) begin m_f = M_SEED; m_lock_f = 1'b1; end
    if (LOCK_EN && m_g == 0) begin m_g = M_SEED; m_lock_g = 1'b1; end
  endtask

  task automatic model_cycle();
    m_lock_f = 1'b0;
    m_lock_g = 1'b0;
    if (rst) begin
      m_f = M_SEED; m_g = M_SEED; m_running = 1'b0; m_left = 0; m_done = 1'b0;
    end else if (load) begin
      if (LOCK_EN && seed_in == 8'h00) begin
        m_f = M_SEED; m_g = M_SEED; m_lock_f = 1'b1; m_lock_g = 1'b1;
      end else begin
        m_f = int'(seed_in); m_g = int'(seed_in);
      end
      m_running = 1'b0; m_done = 1'b0;
    end else if (m_running) begin
      model_adv();
      m_left--;
      if (m_left == 0) begin m_running = 1'b0; m_done = 1'b1; end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (burst_start) begin
      if (burst_len == 16'd0) m_done = 1'b1;
      else begin m_running = 1'b1; m_left = int'(burst_len); end
    end else if (en) begin
      model_adv();
    end
  endtask

  task automatic compare_all();
    check("state_f", st_f, m_f[7:0]);
    check("bit_f",   bit_f, m_f[0]);
    check("busy_f",  busy_f, m_running);
    check("done_f",  done_f, m_done);
    check("lock_f",  lock_f, m_lock_f);
    check("state_g", st_g, m_g[7:0]);
    check("bit_g",   bit_g, m_g[0]);
    check("busy_g",  busy_g, m_running);
    check("done_g",  done_g, m_done);
    check("lock_g",  lock_g, m_lock_g);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_cycle();
    compare_all();
  endtask

  task automatic quiet();
    rst = 1'b0; load = 1'b0; en = 1'b0; burst_start = 1'b0;
    seed_in = 8'h00; burst_len = 16'd0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fib_exp [5];
    int busy_n;
    fib_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    m_f = 0; m_g = 0; m_left = 0;
    m_running = 1'b0; m_done = 1'b0; m_lock_f = 1'b0; m_lock_g = 1'b0;
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_state", st_f, 8'h01);
    check("reset_bit",   bit_f, 1'b1);
    check("reset_busy",  busy_f, 1'b0);
    check("reset_done",  done_f, 1'b0);
    check("reset_lock",  lock_f, 1'b0);

    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fib_seq", st_f, fib_exp[i]);
      if (i == 0) check("gal_step1", st_g, 8'h1D);
      if (i == 1) check("gal_step2", st_g, 8'h13);
    end
    en = 1'b0;
    tick();
    check("idle_hold", st_f, 8'h88);

    // Five-step burst; en is held high to show it has no effect while running.
    do_reset();
    burst_start = 1'b1; burst_len = 16'd5; en = 1'b1;
    tick();
    burst_start = 1'b0;
    busy_n = 0;
    for (int g = 0; g < 20 && busy_f; g++) begin
      busy_n++;
      tick();
    end
    en = 1'b0;
    check("burst_busy_cycles", busy_n, 5);
    check("burst_state", st_f, 8'h88);
    check("burst_done", done_f, 1'b1);
    tick();
    check("burst_done_once", done_f, 1'b0);

    burst_start = 1'b1; burst_len = 16'd0;
    tick();
    burst_start = 1'b0;
    check("len0_done", done_f, 1'b1);
    check("len0_busy", busy_f, 1'b0);
    check("len0_state", st_f, 8'h88);
    tick();
    check("len0_done_once", done_f, 1'b0);

    // Load on the third RUN cycle aborts the burst.
    do_reset();
    burst_start = 1'b1; burst_len = 16'd5;
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    load = 1'b1; seed_in = 8'hA5;
    tick();
    load = 1'b0;
    check("abort_state", st_f, 8'hA5);
    check("abort_busy", busy_f, 1'b0);
    check("abort_done", done_f, 1'b0);
    tick();
    check("abort_no_done", done_f, 1'b0);

    load = 1'b1; seed_in = 8'h3C; burst_start = 1'b1; burst_len = 16'd4;
    tick();
    load = 1'b0; burst_start = 1'b0;
    check("load_wins_state", st_f, 8'h3C);
    check("load_wins_busy", busy_f, 1'b0);

    load = 1'b1; seed_in = 8'h00;
    tick();
    load = 1'b0;
`ifdef LFSR_GEN_LOCKUP_EN
    check("zero_load_state", st_f, 8'h01);
    check("zero_load_lock", lock_f, 1'b1);
    tick();
    check("zero_load_lock_once", lock_f, 1'b0);
`else
    check("zero_load_state", st_f, 8'h00);
    check("zero_load_lock", lock_f, 1'b0);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("zero_stuck_state", st_f, 8'h00);
    check("zero_stuck_lock", lock_f, 1'b0);
`endif

    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      load        = ($urandom_range(0, 15) == 0);
      seed_in     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      en          = $urandom_range(0, 1) == 1;
      burst_start = ($urandom_range(0, 7) == 0);
      burst_len   = 16'($urandom_range(0, 6));
      tick();
    end
    quiet();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
